ide_xfer_seq: RTL and testbench
===============================

# ide_xfer_seq

PIO sector-transfer sequencer that sits between the ATA task-file/data-register logic and the 4096-word IDE sector FIFO. It sequences multi-sector reads and writes and drives the ATA BSY/DRQ/IRQ status bits. It gates CPU data-register strobes into FIFO read/write strobes and handshakes with the IO controller, which fills or drains the FIFO one 256-word sector at a time.

## Interface
Parameters:
- SETTLE, default 2: clk_en cycles to wait after a sector boundary before sampling FIFO flags; covers the FIFO pointer and empty-flag lag.

Ports:
- clk  in  1  bus clock
- reset  in  1  asynchronous, active-high; clears all state immediately
- clk_en  in  1  all registered state advances only when high
- cmd_read  in  1  one-cycle pulse: start PIO read; ignored unless IDLE
- cmd_write  in  1  one-cycle pulse: start PIO write; ignored unless IDLE
- cmd_abort  in  1  return to IDLE from any state
- sec_count  in  8  sector count, latched at command start; 0 means 256
- cpu_data_rd  in  1  one pulse per 16-bit data-register read
- cpu_data_wr  in  1  one pulse per 16-bit data-register write
- irq_ack  in  1  clears irq (status-register read)
- fifo_full  in  1  FIFO holds ≥1 full sector
- fifo_empty  in  1  FIFO empty
- fifo_rd  out  1  FIFO read strobe (combinational)
- fifo_wr  out  1  FIFO write strobe (combinational)
- fifo_reset  out  1  one-cycle FIFO pointer reset (registered)
- host_req_rd  out  1  asks IO controller to load sectors into FIFO
- host_req_wr  out  1  asks IO controller to drain one sector from FIFO
- bsy  out  1  ATA BSY
- drq  out  1  ATA DRQ
- irq  out  1  ATA INTRQ, sticky until irq_ack
- sectors_left  out  9  remaining sectors, 1..256 during a command

## Operation
- Registers: state, word counter wcnt[7:0], sectors_left[8:0], settle counter, irq.
- Strobe gating:
  - fifo_rd = cpu_data_rd & clk_en & (state==RD_DRQ).
  - fifo_wr = cpu_data_wr & clk_en & (state==WR_DRQ).
  - Strobes arriving in any other state are dropped and do not count.
- IDLE: bsy=0, drq=0.
  - cmd_read: sectors_left = (sec_count==0 ? 256 : sec_count), wcnt=0, fifo_reset=1 next cycle, go to RD_WAIT.
  - cmd_write: same latching, go to WR_DRQ.
  - cmd_read and cmd_write in the same cycle: read wins.
- RD_WAIT: bsy=1, host_req_rd=1. Load settle counter = SETTLE on entry; sample fifo_full only after it reaches 0. On fifo_full: irq=1, go to RD_DRQ.
- RD_DRQ: bsy=0, drq=1, host_req_rd stays 1 so the host may prefetch.
  - Each gated read increments wcnt.
  - A read at wcnt==255 ends the sector: wcnt wraps to 0 and sectors_left decrements.
  - If sectors_left was 1, go to IDLE and drop host_req_rd; otherwise go to RD_WAIT.
- WR_DRQ: bsy=0, drq=1. No irq on entry for the first sector. Each gated write increments wcnt; a write at wcnt==255 goes to WR_WAIT.
- WR_WAIT: bsy=1, drq=0, host_req_wr=1. After settle, on fifo_empty:
  - sectors_left decrements and irq=1.
  - If sectors_left was 1, go to IDLE; otherwise go to WR_DRQ.
- cmd_abort (precedence over every other event, including a same-cycle start): go to IDLE, wcnt=0, sectors_left=0, fifo_reset pulse, host requests drop. irq is unchanged.
- irq_ack clears irq. When a set and irq_ack coincide, set wins.

## Timing
- Reset values: state IDLE, all outputs 0, sectors_left 0, wcnt 0.
- fifo_rd/fifo_wr: zero latency from the CPU strobe. The FIFO pointer advances on the strobe's falling edge.
- fifo_reset: asserted the first clk_en cycle after the accepted command or abort, for exactly one clk_en cycle.
- Status: bsy/drq/host_req change on the clk_en edge that changes state; they are registered decodes of state.
- Last read of a non-final sector: drq falls 1 cycle after the 256th strobe. fifo_full is not sampled until SETTLE clk_en cycles later, so a stale full flag from the previous sector is never accepted.
- clk_en low: strobes are ignored, nothing advances, outputs hold.
- Reset asserted mid-transfer: immediate return to reset values without waiting for clk_en. fifo_reset is not pulsed.

## Test plan
- Reset mid-RD_DRQ, with irq set and wcnt=100 → bsy=drq=irq=0, sectors_left=0, all strobes blocked at once; then cmd_read, sec_count=1, completes normally.
- Read, sec_count=2; host raises fifo_full, keeps it high through sector 1 and drops it SETTLE+1 cycles after the 256th read → irq at each DRQ entry, exactly 512 fifo_rd, sectors_left 2→1→0, second DRQ entered only after the stale full is gone.
- Write, sec_count=1 → drq=1, irq=0; 256 cpu_data_wr → 256 fifo_wr, bsy=1, host_req_wr=1; fifo_empty asserted → irq=1, IDLE, sectors_left=0.
- sec_count=0 read → sectors_left=256; run 256 sectors → 65536 fifo_rd, sectors_left reaches 0 exactly at the last word.
- cpu_data_rd pulses in IDLE and RD_WAIT, and cmd_write during RD_DRQ → no fifo_rd, wcnt unchanged, state unchanged.
- cmd_abort at wcnt=100 in WR_DRQ → IDLE next cycle, one fifo_reset pulse, drq=0, irq unchanged; irq_ack then clears irq.

Source files
------------

// File: rtl/ide_xfer_seq.sv
// PIO sector-transfer sequencer between the ATA data register and the IDE sector FIFO.
// It paces multi-sector reads and writes and drives the BSY/DRQ/INTRQ status bits.
//
//   state   | meaning
//   IDLE    | no command; bsy=0, drq=0
//   RD_WAIT | waiting for the host to fill one sector into the FIFO
//   RD_DRQ  | CPU reading the current sector out of the FIFO
//   WR_DRQ  | CPU writing the current sector into the FIFO
//   WR_WAIT | waiting for the host to drain the written sector
module ide_xfer_seq #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       cmd_read,
  input  logic       cmd_write,
  input  logic       cmd_abort,
  input  logic [7:0] sec_count,
  input  logic       cpu_data_rd,
  input  logic       cpu_data_wr,
  input  logic       irq_ack,
  input  logic       fifo_full,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  output logic       fifo_wr,
  output logic       fifo_reset,
  output logic       host_req_rd,
  output logic       host_req_wr,
  output logic       bsy,
  output logic       drq,
  output logic       irq,
  output logic [8:0] sectors_left
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_DRQ  = 3'd2,
    WR_DRQ  = 3'd3,
    WR_WAIT = 3'd4
  } state_t;

  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  state_t        state, state_nx;
  logic [7:0]    wcnt, wcnt_nx;
  logic [8:0]    left_nx;
  logic [SW-1:0] settle_cnt, settle_nx;
  logic          irq_set;
  logic          fifo_reset_nx;

  assign fifo_rd     = cpu_data_rd & clk_en & (state == RD_DRQ);
  assign fifo_wr     = cpu_data_wr & clk_en & (state == WR_DRQ);
  assign bsy         = (state == RD_WAIT) | (state == WR_WAIT);
  assign drq         = (state == RD_DRQ) | (state == WR_DRQ);
  assign host_req_rd = (state == RD_WAIT) | (state == RD_DRQ);
  assign host_req_wr = (state == WR_WAIT);

  always_comb begin
    state_nx      = state;
    wcnt_nx       = wcnt;
    left_nx       = sectors_left;
    settle_nx     = settle_cnt;
    irq_set       = 1'b0;
    fifo_reset_nx = 1'b0;
    if (cmd_abort) begin
      state_nx      = IDLE;
      wcnt_nx       = 8'd0;
      left_nx       = 9'd0;
      fifo_reset_nx = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_read | cmd_write) begin
            left_nx       = (sec_count == 8'd0) ? 9'd256 : {1'b0, sec_count};
            wcnt_nx       = 8'd0;
            fifo_reset_nx = 1'b1;
            if (cmd_read) begin
              state_nx  = RD_WAIT;
              settle_nx = SW'(SETTLE);
            end else begin
              state_nx  = WR_DRQ;
            end
          end
        end
        // FIFO flags lag the pointers, so they are ignored until the settle count expires
        RD_WAIT: begin
          if (settle_cnt != '0) begin
            settle_nx = settle_cnt - 1'b1;
          end else if (fifo_full) begin
            irq_set  = 1'b1;
            state_nx = RD_DRQ;
          end
        end
        RD_DRQ: begin
          if (cpu_data_rd) begin
            wcnt_nx = wcnt + 8'd1;
            if (wcnt == 8'd255) begin
              left_nx = sectors_left - 9'd1;
              if (sectors_left == 9'd1) begin
                state_nx = IDLE;
              end else begin
                state_nx  = RD_WAIT;
                settle_nx = SW'(SETTLE);
              end
            end
          end
        end
        WR_DRQ: begin
          if (cpu_data_wr) begin
            wcnt_nx = wcnt + 8'd1;
            if (wcnt == 8'd255) begin
              state_nx  = WR_WAIT;
              settle_nx = SW'(SETTLE);
            end
          end
        end
        WR_WAIT: begin
          if (settle_cnt != '0) begin
            settle_nx = settle_cnt - 1'b1;
          end else if (fifo_empty) begin
            left_nx  = sectors_left - 9'd1;
            irq_set  = 1'b1;
            state_nx = (sectors_left == 9'd1) ? IDLE : WR_DRQ;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wcnt         <= 8'd0;
      sectors_left <= 9'd0;
      settle_cnt   <= '0;
      irq          <= 1'b0;
      fifo_reset   <= 1'b0;
    end else if (clk_en) begin
      state        <= state_nx;
      wcnt         <= wcnt_nx;
      sectors_left <= left_nx;
      settle_cnt   <= settle_nx;
      irq          <= irq_set | (irq & ~irq_ack);
      fifo_reset   <= fifo_reset_nx;
    end
  end

endmodule

// File: tb/tb_ide_xfer_seq.sv
// Randomized bench for ide_xfer_seq: a transaction-level model of the sector transfer
// predicts every output each cycle; a behavioural host drives the FIFO flags.
module tb_ide_xfer_seq;

  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       reset, clk_en, cmd_read, cmd_write, cmd_abort;
  logic [7:0] sec_count;
  logic       cpu_data_rd, cpu_data_wr, irq_ack, fifo_full, fifo_empty;
  logic       fifo_rd, fifo_wr, fifo_reset, host_req_rd, host_req_wr;
  logic       bsy, drq, irq;
  logic [8:0] sectors_left;

  ide_xfer_seq #(.SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .cmd_read(cmd_read), .cmd_write(cmd_write), .cmd_abort(cmd_abort),
    .sec_count(sec_count), .cpu_data_rd(cpu_data_rd), .cpu_data_wr(cpu_data_wr),
    .irq_ack(irq_ack), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .fifo_wr(fifo_wr), .fifo_reset(fifo_reset),
    .host_req_rd(host_req_rd), .host_req_wr(host_req_wr),
    .bsy(bsy), .drq(drq), .irq(irq), .sectors_left(sectors_left)
  );

  always #5 clk = ~clk;

  int n_checks, n_errors;
  int rd_seen, wr_seen;

  // transfer model: active command, direction, waiting on host or on CPU
  bit m_active, m_rd, m_wait, m_irq, m_frst;
  int m_words, m_left, m_total, m_ecyc, m_wstart, host_d;
  bit p_en_rand, p_ack, p_spur, p_dense;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_rd = 0; m_wait = 0; m_irq = 0; m_frst = 0;
    m_words = 0; m_left = 0; m_total = 0; m_ecyc = 0; m_wstart = 0;
  endtask

  task automatic check_outputs();
    chk("bsy", bsy, m_active & m_wait);
    chk("drq", drq, m_active & !m_wait);
    chk("host_req_rd", host_req_rd, m_active & m_rd);
    chk("host_req_wr", host_req_wr, m_active & !m_rd & m_wait);
    chk("irq", irq, m_irq);
    chk("fifo_reset", fifo_reset, m_frst);
    chk("sectors_left", sectors_left, m_left);
  endtask

  task automatic new_host_delay();
    host_d = p_dense ? 0 : int'($urandom_range(0, 4));
  endtask

  task automatic model_step();
    bit set_irq;
    set_irq = 0;
    if (!clk_en) return;
    m_frst = 0;
    if (cmd_abort) begin
      m_active = 0; m_words = 0; m_left = 0; m_frst = 1;
    end else if (!m_active) begin
      if (cmd_read || cmd_write) begin
        m_active = 1; m_rd = cmd_read; m_wait = cmd_read; m_wstart = m_ecyc;
        m_left = (sec_count == 0) ? 256 : int'(sec_count);
        m_total = m_left; m_words = 0; m_frst = 1;
        new_host_delay();
      end
    end else if (m_wait) begin
      if (m_ecyc - m_wstart >= SETTLE + 1) begin
        if (m_rd && fifo_full) begin
          m_wait = 0; set_irq = 1;
        end else if (!m_rd && fifo_empty) begin
          m_left--; set_irq = 1;
          if (m_left == 0) m_active = 0; else m_wait = 0;
        end
      end
    end else if ((m_rd && cpu_data_rd) || (!m_rd && cpu_data_wr)) begin
      m_words++;
      if (m_words == 256) begin
        m_words = 0;
        if (m_rd) m_left--;
        if (m_rd && m_left == 0) m_active = 0;
        else begin
          m_wait = 1; m_wstart = m_ecyc; new_host_delay();
        end
      end
    end
    m_irq = set_irq || (m_irq && !irq_ack);
    m_ecyc++;
  endtask

  // CPU and host stimulus for one cycle; the host keeps flags stale through the settle window
  task automatic set_inputs();
    int since;
    since = m_ecyc - m_wstart;
    clk_en    = p_en_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
    irq_ack   = p_ack ? ($urandom_range(0, 15) == 0) : 1'b0;
    cmd_abort = 1'b0;
    cmd_read  = (p_spur && m_active) ? ($urandom_range(0, 31) == 0) : 1'b0;
    cmd_write = (p_spur && m_active) ? ($urandom_range(0, 31) == 0) : 1'b0;
    sec_count = 8'($urandom);
    if (m_active && !m_wait) begin
      cpu_data_rd = m_rd ? (p_dense ? 1'b1 : ($urandom_range(0, 3) != 0)) : ($urandom_range(0, 3) == 0);
      cpu_data_wr = !m_rd ? (p_dense ? 1'b1 : ($urandom_range(0, 3) != 0)) : ($urandom_range(0, 3) == 0);
    end else begin
      cpu_data_rd = ($urandom_range(0, 7) == 0);
      cpu_data_wr = ($urandom_range(0, 7) == 0);
    end
    if (m_active && m_rd)
      fifo_full = !m_wait ? 1'b1 :
                  (since < SETTLE + 1) ? (m_left != m_total) : (since >= SETTLE + 1 + host_d);
    else
      fifo_full = 1'b0;
    if (m_active && !m_rd)
      fifo_empty = !m_wait ? (m_words == 0) :
                   (since < SETTLE + 1) ? 1'b1 : (since >= SETTLE + 1 + host_d);
    else
      fifo_empty = 1'b1;
  endtask

  // inputs are applied at posedge+1; strobes checked at +3, registered outputs at next posedge+1
  task automatic tick();
    #2;
    chk("fifo_rd", fifo_rd, cpu_data_rd & clk_en & m_active & m_rd & !m_wait);
    chk("fifo_wr", fifo_wr, cpu_data_wr & clk_en & m_active & !m_rd & !m_wait);
    if (fifo_rd === 1'b1) rd_seen++;
    if (fifo_wr === 1'b1) wr_seen++;
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic start_cmd(input bit rd, input logic [7:0] sc, input bit both);
    set_inputs();
    clk_en = 1'b1; cmd_abort = 1'b0;
    cmd_read = rd | both; cmd_write = !rd | both; sec_count = sc;
    tick();
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (m_active && n < budget) begin
      set_inputs(); tick(); n++;
    end
    chk({tag, "_done"}, m_active, 0);
  endtask

  task automatic run_to_word(input int word, input int need_left, input int budget, input string tag);
    int n;
    n = 0;
    while (!(m_active && !m_wait && m_words == word && (need_left == 0 || m_left == need_left))
           && n < budget) begin
      set_inputs(); tick(); n++;
    end
    chk({tag, "_reached"}, n < budget, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_errors = 0; rd_seen = 0; wr_seen = 0;
    p_en_rand = 0; p_ack = 0; p_spur = 0; p_dense = 0; host_d = 0;
    reset = 1'b1; clk_en = 1'b0; cmd_read = 1'b0; cmd_write = 1'b0; cmd_abort = 1'b0;
    sec_count = 8'd0; cpu_data_rd = 1'b0; cpu_data_wr = 1'b0; irq_ack = 1'b0;
    fifo_full = 1'b0; fifo_empty = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b0;

    // reset in the middle of a read sector with irq pending
    p_en_rand = 1;
    start_cmd(1, 8'd3, 0);
    run_to_word(100, 0, 3000, "rst");
    chk("rst_pre_irq", irq, 1);
    clk_en = 1'b1; cpu_data_rd = 1'b1; cpu_data_wr = 1'b1; cmd_read = 1'b0; cmd_write = 1'b0;
    #2;
    chk("rst_pre_fifo_rd", fifo_rd, 1);
    reset = 1'b1;
    #1;
    chk("rst_bsy", bsy, 0);
    chk("rst_drq", drq, 0);
    chk("rst_irq", irq, 0);
    chk("rst_left", sectors_left, 0);
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_fifo_wr", fifo_wr, 0);
    chk("rst_hreq", {host_req_rd, host_req_wr}, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0; cpu_data_rd = 1'b0; cpu_data_wr = 1'b0;
    check_outputs();
    rd_seen = 0;
    start_cmd(1, 8'd1, 0);
    run_until_idle(3000, "rd1");
    chk("rd1_count", rd_seen, 256);

    // two-sector read, random clk_en and acks
    p_ack = 1; rd_seen = 0;
    start_cmd(1, 8'd2, 0);
    run_until_idle(5000, "rd2");
    chk("rd2_count", rd_seen, 512);
    chk("rd2_left", sectors_left, 0);

    // simultaneous start (read wins) with spurious commands mid-transfer
    p_spur = 1; rd_seen = 0; wr_seen = 0;
    start_cmd(1, 8'd3, 1);
    chk("both_hreq_rd", host_req_rd, 1);
    run_until_idle(6000, "rd3");
    chk("rd3_count", rd_seen, 768);
    chk("rd3_wr_count", wr_seen, 0);

    // single-sector write
    p_spur = 0; p_en_rand = 0; p_ack = 0;
    set_inputs(); irq_ack = 1'b1; clk_en = 1'b1; tick();
    wr_seen = 0;
    start_cmd(0, 8'd1, 0);
    chk("wr1_drq", drq, 1);
    chk("wr1_irq", irq, 0);
    run_until_idle(3000, "wr1");
    chk("wr1_count", wr_seen, 256);
    chk("wr1_irq_end", irq, 1);

    // four-sector write, random everything
    p_en_rand = 1; p_ack = 1; p_spur = 1; wr_seen = 0;
    start_cmd(0, 8'd4, 0);
    run_until_idle(8000, "wr4");
    chk("wr4_count", wr_seen, 1024);

    // abort at word 100 of the second write sector, same-cycle start ignored
    p_ack = 0; p_spur = 0;
    start_cmd(0, 8'd2, 0);
    run_to_word(100, 1, 4000, "ab");
    chk("ab_pre_irq", irq, 1);
    set_inputs();
    clk_en = 1'b1; cmd_abort = 1'b1; cmd_read = 1'b1; irq_ack = 1'b0;
    tick();
    chk("ab_drq", drq, 0);
    chk("ab_fifo_reset", fifo_reset, 1);
    chk("ab_irq", irq, 1);
    chk("ab_left", sectors_left, 0);
    set_inputs(); clk_en = 1'b1; irq_ack = 1'b0;
    tick();
    chk("ab_fifo_reset_end", fifo_reset, 0);
    chk("ab_irq_hold", irq, 1);
    set_inputs(); clk_en = 1'b1; irq_ack = 1'b1;
    tick();
    chk("ab_ack", irq, 0);

    // sec_count 0 means 256 sectors, full-speed reads
    p_en_rand = 0; p_dense = 1; rd_seen = 0;
    start_cmd(1, 8'd0, 0);
    chk("rd256_left", sectors_left, 256);
    run_until_idle(80000, "rd256");
    chk("rd256_count", rd_seen, 65536);
    chk("rd256_left_end", sectors_left, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
